// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side conditional branch predictor. A PC-indexed table of 2-bit
// saturating counters supplies the taken/not-taken guess and the
// PC-relative target for the fetch PC mux. Each prediction travels down a
// small tracking pipeline so that it appears at execute as br_pred_taken_x,
// where the resolver's outcome trains the table and updates the statistics.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   pc_f            fetch-stage PC
//   inst_f          fetch-stage instruction
//   pipe_stall      freeze the tracking pipeline (and training)
//   pipe_flush      discard all in-flight predictions
//   is_br_check     execute instruction is a conditional branch
//   br_taken_check  resolved direction of the execute branch
//   br_pred_taken   fetch-stage prediction (combinational)
//   br_pred_target  fetch-stage predicted target (combinational)
//   br_pred_taken_x prediction aligned to execute (from registers only)
//   br_total        number of trained branches
//   br_mispred      number of mispredicted branches
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES    = 32,
  parameter int IDX_W      = 5,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_f,
  input  logic [31:0]      inst_f,
  input  logic             pipe_stall,
  input  logic             pipe_flush,
  input  logic             is_br_check,
  input  logic             br_taken_check,
  output logic             br_pred_taken,
  output logic [31:0]      br_pred_target,
  output logic             br_pred_taken_x,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_mispred
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] CTR_RESET  = 2'b01;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup
  // ---------------------------------------------------------------------------
  logic [1:0]       ctr_q [ENTRIES];
  logic             is_branch_f;
  logic [IDX_W-1:0] idx_f;
  logic [31:0]      imm_f;

  assign is_branch_f    = (inst_f[6:0] == OPC_BRANCH);
  assign idx_f          = pc_f[IDX_W+1:2];
  assign br_pred_taken  = is_branch_f & ctr_q[idx_f][1];
  assign imm_f          = {{19{inst_f[31]}}, inst_f[31], inst_f[7],
                           inst_f[30:25], inst_f[11:8], 1'b0};
  assign br_pred_target = pc_f + imm_f;

  // Instruction bits that do not take part in B-type decode.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst_f[24:12];

  // ---------------------------------------------------------------------------
  // Tracking pipeline: stage 0 loads from fetch, stage PIPE_DEPTH-1 is head.
  // ---------------------------------------------------------------------------
  logic             stg_valid_q [PIPE_DEPTH];
  logic [IDX_W-1:0] stg_idx_q   [PIPE_DEPTH];
  logic             stg_pred_q  [PIPE_DEPTH];

  logic flush_pend_q, flush_pend_d;
  logic advance;
  logic flush_eff;

  // A flush seen while stalled is remembered and applied on the first
  // edge where the pipeline is allowed to move again.
  assign advance      = ~pipe_stall;
  assign flush_eff    = pipe_flush | flush_pend_q;
  assign flush_pend_d = pipe_stall ? (flush_pend_q | pipe_flush) : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_pend_q <= 1'b0;
    else        flush_pend_q <= flush_pend_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      logic             src_valid;
      logic [IDX_W-1:0] src_idx;
      logic             src_pred;

      if (gi == 0) begin : g_src_fetch
        assign src_valid = is_branch_f;
        assign src_idx   = idx_f;
        assign src_pred  = br_pred_taken;
      end else begin : g_src_prev
        assign src_valid = stg_valid_q[gi-1];
        assign src_idx   = stg_idx_q[gi-1];
        assign src_pred  = stg_pred_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_valid_q[gi] <= 1'b0;
          stg_idx_q[gi]   <= '0;
          stg_pred_q[gi]  <= 1'b0;
        end else if (advance) begin
          stg_valid_q[gi] <= src_valid & ~flush_eff;
          stg_idx_q[gi]   <= src_idx;
          stg_pred_q[gi]  <= src_pred;
        end
      end
    end
  endgenerate

  logic             head_valid;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;

  assign head_valid      = stg_valid_q[PIPE_DEPTH-1];
  assign head_idx        = stg_idx_q[PIPE_DEPTH-1];
  assign head_pred       = stg_pred_q[PIPE_DEPTH-1];
  assign br_pred_taken_x = head_valid & head_pred;

  // ---------------------------------------------------------------------------
  // Training: the head advances on the same edge, so each branch trains once.
  // Flush does not cancel training of the head.
  // ---------------------------------------------------------------------------
  logic       train;
  logic [1:0] ctr_cur;
  logic [1:0] ctr_upd;

  assign train   = is_br_check & head_valid & ~pipe_stall;
  assign ctr_cur = ctr_q[head_idx];

  always_comb begin
    ctr_upd = ctr_cur;
    if (br_taken_check) begin
      if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'd1;
    end
  end

  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    ctr_q[gi] <= CTR_RESET;
        else if (train && (head_idx == IDX_W'(gi)))    ctr_q[gi] <= ctr_upd;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Statistics (wrap naturally)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] mispred_q, mispred_d;

  always_comb begin
    total_d   = total_q;
    mispred_d = mispred_q;
    if (train) begin
      total_d = total_q + CNT_W'(1);
      if (head_pred != br_taken_check) mispred_d = mispred_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      mispred_q <= '0;
    end else begin
      total_q   <= total_d;
      mispred_q <= mispred_d;
    end
  end

  assign br_total   = total_q;
  assign br_mispred = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed stimulus for branch_predictor. Each stimulus step queues the
// values it expects; a separate monitor drains the queue on the falling
// clock edge (or on an explicit kick for asynchronous reset checks) and
// compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int CNT_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BR  = 32'h0020_8463; // beq, offset +8
  localparam logic [31:0] NEG = 32'hFE00_0EE3; // beq, offset -4

  localparam int S_PRED   = 0;
  localparam int S_TARGET = 1;
  localparam int S_TX     = 2;
  localparam int S_TOTAL  = 3;
  localparam int S_MISP   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      pc_f = '0;
  logic [31:0]      inst_f = NOP;
  logic             pipe_stall = 1'b0;
  logic             pipe_flush = 1'b0;
  logic             is_br_check = 1'b0;
  logic             br_taken_check = 1'b0;
  logic             br_pred_taken;
  logic [31:0]      br_pred_target;
  logic             br_pred_taken_x;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_mispred;

  branch_predictor #(
    .ENTRIES(32), .IDX_W(5), .PIPE_DEPTH(2), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_f           (pc_f),
    .inst_f         (inst_f),
    .pipe_stall     (pipe_stall),
    .pipe_flush     (pipe_flush),
    .is_br_check    (is_br_check),
    .br_taken_check (br_taken_check),
    .br_pred_taken  (br_pred_taken),
    .br_pred_target (br_pred_target),
    .br_pred_taken_x(br_pred_taken_x),
    .br_total       (br_total),
    .br_mispred     (br_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event mon_kick;

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      S_PRED:   return {31'd0, br_pred_taken};
      S_TARGET: return br_pred_target;
      S_TX:     return {31'd0, br_pred_taken_x};
      S_TOTAL:  return br_total;
      default:  return br_mispred;
    endcase
  endfunction

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or mon_kick);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = dut_val(e.sel);
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
        end else begin
          $display("[TB] ok   %s = 0x%08h", e.name, act);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic chk, input logic tkn,
                       input logic stall, input logic flush);
    pc_f           = pc;
    inst_f         = inst;
    is_br_check    = chk;
    br_taken_check = tkn;
    pipe_stall     = stall;
    pipe_flush     = flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    drive(32'h0, NOP, 0, 0, 0, 0);
    expect_val("reset_pred", S_PRED, 32'd0);
    expect_val("reset_tx", S_TX, 32'd0);
    expect_val("reset_total", S_TOTAL, 32'd0);
    expect_val("reset_misp", S_MISP, 32'd0);
    step();

    // First lookup and forward target; then train taken twice
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t1_pred", S_PRED, 32'd0);
    expect_val("t1_target", S_TARGET, 32'h108);
    step();
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t2_pred_second", S_PRED, 32'd0);
    step();
    drive(32'h0, NOP, 1, 1, 0, 0);
    expect_val("t1_tx_after2", S_TX, 32'd0);
    step();
    drive(32'h0, NOP, 1, 1, 0, 0);
    expect_val("t2_total_1", S_TOTAL, 32'd1);
    expect_val("t2_misp_1", S_MISP, 32'd1);
    step();
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t2_pred_third", S_PRED, 32'd1);
    expect_val("t2_total_2", S_TOTAL, 32'd2);
    expect_val("t2_misp_2", S_MISP, 32'd2);
    step();

    // Predicted taken, resolved not-taken together with a flush
    drive(32'h0, NOP, 0, 0, 0, 0);
    step();
    drive(32'h100, BR, 1, 0, 0, 1);
    expect_val("t3_tx_head", S_TX, 32'd1);
    step();
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t3_tx_flushed", S_TX, 32'd0);
    expect_val("t3_total", S_TOTAL, 32'd3);
    expect_val("t3_misp", S_MISP, 32'd3);
    expect_val("t3_pred_ctr10", S_PRED, 32'd1);
    step();
    drive(32'h0, NOP, 0, 0, 0, 0);
    expect_val("t3_tx_load_flushed", S_TX, 32'd0);
    step();
    drive(32'h0, NOP, 1, 0, 0, 0);
    expect_val("t3_tx_next", S_TX, 32'd1);
    step();
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t3_pred_ctr01", S_PRED, 32'd0);
    expect_val("t3_total_4", S_TOTAL, 32'd4);
    expect_val("t3_misp_4", S_MISP, 32'd4);
    step();

    // Stall holds a valid head: no training until release, then one update
    drive(32'h104, BR, 0, 0, 0, 0);
    expect_val("t4_pred_idx1", S_PRED, 32'd0);
    step();
    drive(32'h0, NOP, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, NOP, 1, 1, 1, 0);
      expect_val($sformatf("t4_stall%0d_total", i), S_TOTAL, 32'd4);
      step();
    end
    drive(32'h0, NOP, 1, 1, 0, 0);
    expect_val("t4_release_total", S_TOTAL, 32'd4);
    step();
    drive(32'h0, NOP, 1, 1, 0, 0);
    expect_val("t4_total_once", S_TOTAL, 32'd5);
    expect_val("t4_misp", S_MISP, 32'd5);
    step();
    drive(32'h0, NOP, 0, 0, 0, 0);
    expect_val("t4_invalid_head_ignored", S_TOTAL, 32'd5);
    step();

    // Flush during stall is applied when the stall releases
    drive(32'h104, BR, 0, 0, 0, 0);
    expect_val("t4b_pred_idx1", S_PRED, 32'd1);
    step();
    drive(32'h0, NOP, 0, 0, 1, 1);
    expect_val("t4b_tx_stalled", S_TX, 32'd0);
    step();
    drive(32'h0, NOP, 0, 0, 0, 0);
    expect_val("t4b_tx_release", S_TX, 32'd0);
    step();
    drive(32'h0, NOP, 0, 0, 0, 0);
    expect_val("t4b_tx_pending_flush", S_TX, 32'd0);
    step();

    // Negative offset and wrap
    drive(32'h200, NEG, 0, 0, 0, 0);
    expect_val("t5_target_neg", S_TARGET, 32'h1FC);
    expect_val("t5_pred", S_PRED, 32'd0);
    step();
    drive(32'h0, NEG, 0, 0, 0, 0);
    expect_val("t5_target_wrap", S_TARGET, 32'hFFFF_FFFC);
    step();
    drive(32'h0, NOP, 0, 0, 0, 0);
    step();
    step();

    // Saturate ctr[0] again, then assert reset between clock edges
    drive(32'h100, BR, 0, 0, 0, 0);
    step();
    step();
    drive(32'h0, NOP, 1, 1, 0, 0);
    step();
    step();
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t6_pred_sat", S_PRED, 32'd1);
    expect_val("t6_total_7", S_TOTAL, 32'd7);
    expect_val("t6_misp_7", S_MISP, 32'd7);
    step();
    drive(32'h0, NOP, 0, 0, 0, 0);
    step();
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t6_tx_before_rst", S_TX, 32'd1);
    expect_val("t6_pred_before_rst", S_PRED, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    expect_val("t6_async_pred", S_PRED, 32'd0);
    expect_val("t6_async_tx", S_TX, 32'd0);
    expect_val("t6_async_total", S_TOTAL, 32'd0);
    expect_val("t6_async_misp", S_MISP, 32'd0);
    -> mon_kick;
    #1;
    step();
    rst_n = 1'b1;
    drive(32'h100, BR, 0, 0, 0, 0);
    expect_val("t6_post_pred", S_PRED, 32'd0);
    expect_val("t6_post_total", S_TOTAL, 32'd0);
    step();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end counterpart of the execute-stage PC-select / branch-resolution logic.
- Predicts conditional branches at fetch with a PC-indexed table of 2-bit saturating counters. Produces the predicted direction and target for the fetch PC mux.
- Carries each prediction down the pipeline and presents it at execute as br_pred_taken_x, which drives the resolver's br_pred_taken_o input.
- Consumes the resolver's is_br_check / br_taken_check to train the table. Keeps branch and mispredict statistics.

Parameters:
ENTRIES, 32, number of counter entries; power of 2, at least 2
IDX_W, 5, log2(ENTRIES); table index = pc_f[IDX_W+1:2]
PIPE_DEPTH, 2, pipeline registers between fetch and execute (at least 1)
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_f  input  32  fetch-stage PC
inst_f  input  32  fetch-stage instruction
pipe_stall  input  1  front end and execute hold; tracking pipeline frozen
pipe_flush  input  1  execute redirect; younger in-flight predictions discarded
is_br_check  input  1  execute instruction is a conditional branch
br_taken_check  input  1  resolved direction of the execute branch
br_pred_taken  output  1  fetch-stage prediction, combinational
br_pred_target  output  32  fetch-stage predicted target, combinational
br_pred_taken_x  output  1  prediction aligned to the execute stage
br_total  output  CNT_W  count of trained branches
br_mispred  output  CNT_W  count of mispredicted branches

Behaviour:
- is_branch_f = (inst_f[6:0] == 7'b1100011).
- br_pred_taken = is_branch_f & ctr[idx_f][1], where idx_f = pc_f[IDX_W+1:2].
- br_pred_target = pc_f + sext({inst_f[31], inst_f[7], inst_f[30:25], inst_f[11:8], 1'b0}), computed in 32-bit arithmetic with wrap. It is computed every cycle and is meaningful only when br_pred_taken = 1.
- Tracking pipeline: PIPE_DEPTH stages, each holding {valid, idx, pred}. Stage 0 loads {is_branch_f, idx_f, br_pred_taken}. The last stage is the head and is aligned with execute.
- br_pred_taken_x = head.valid & head.pred. It is registered and has no combinational path from inputs.
- Shift rules:
  - pipe_stall = 1: all stages hold. Stall takes priority over flush for holding; a pending flush is applied when the stall releases.
  - pipe_flush = 1 and pipe_stall = 0: every stage, including the stage-0 load, becomes valid = 0 on that edge.
  - Otherwise: shift one stage per cycle.
- Training fires on an edge when is_br_check & head.valid & !pipe_stall:
  - ctr[head.idx] increments if br_taken_check = 1, saturating at 2'b11.
  - ctr[head.idx] decrements if br_taken_check = 0, saturating at 2'b00.
  - br_total increments by 1.
  - br_mispred increments by 1 if head.pred != br_taken_check.
  - Both statistics counters wrap modulo 2^CNT_W.
- Training occurs at most once per branch, because the head advances on the same edge.
- is_br_check while head.valid = 0 is ignored: no table update, no count.
- Simultaneous training and fetch lookup of the same index: fetch reads the pre-update value. There is no bypass; the new value is visible the next cycle.
- A flush on the same edge as training: the training still completes. The flush affects only the pipeline contents.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - all ctr = 2'b01 (weakly not-taken)
  - all stage valid = 0, idx = 0, pred = 0
  - br_total = 0, br_mispred = 0
  - br_pred_taken_x = 0
  - br_pred_taken = 0 unless inst_f is a branch whose entry reads 1x, which cannot occur immediately after reset
- Non-branch instructions never train and never predict taken.

Test Plan:
- Reset, then present branch inst_f = 0x00208463 at pc_f = 0x100 -> br_pred_taken = 0; br_pred_target = 0x108; br_pred_taken_x = 0 after 2 cycles.
- Same branch resolved taken twice (is_br_check = 1, br_taken_check = 1 at the head) -> ctr[0] = 01→10→11; third fetch gives br_pred_taken = 1; br_total = 2, br_mispred = 2.
- Branch predicted taken, then resolved not-taken with pipe_flush = 1 on the same edge -> ctr decrements to 10; br_mispred increments; next cycle all stages are invalid and br_pred_taken_x = 0.
- pipe_stall held 3 cycles with is_br_check = 1 at a valid head -> no training until the stall drops, then exactly one increment of br_total.
- Negative offset: inst_f = 0xFE000EE3 at pc_f = 0x200 -> br_pred_target = 0x1FC (0x200 − 4); pc_f = 0x0 with a negative offset wraps to 0xFFFFFFFC.
- Assert rst_n low mid-sequence with counters at 11 and statistics nonzero -> all outputs and state return to reset values immediately, without waiting for a clock edge.
